// File: rtl/sparse_pkg.sv
// Shared types and default sizes for the row-wise sparse x dense datapath.
package sparse_pkg;

    localparam int DEFAULT_ACC_W   = 64;
    localparam int DEFAULT_ADDR_W  = 10;
    localparam int DEFAULT_ROW_LEN = 64;

    typedef enum logic {ACCUM, DRAIN} racc_state_t;

    typedef logic signed [DEFAULT_ACC_W-1:0] acc_t;

    // Two's complement overflow: equal operand signs producing a sum of the other sign.
    function automatic logic sign_ovf(input logic signA, input logic signB, input logic signSum);
        return (signA == signB) && (signSum != signA);
    endfunction

endpackage

// File: rtl/row_accumulator_if.sv
// Product-beat input and result-element output bundle of the row accumulator.
interface row_accumulator_if #(
    parameter int ADDR_W = sparse_pkg::DEFAULT_ADDR_W,
    parameter int ACC_W  = sparse_pkg::DEFAULT_ACC_W
);
    logic              in_valid;
    logic              in_ready;
    logic              in_zeros;
    logic              in_last;
    logic [ADDR_W-1:0] in_addr;
    logic [ACC_W-1:0]  in_data1;
    logic [ACC_W-1:0]  in_data2;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic [15:0]       row_idx;
    logic              ovf;
    logic              addr_err;

    modport master (
        output in_valid, in_zeros, in_last, in_addr, in_data1, in_data2, out_ready,
        input  in_ready, out_valid, out_data, out_addr, out_last, row_idx, ovf, addr_err
    );

    modport slave (
        input  in_valid, in_zeros, in_last, in_addr, in_data1, in_data2, out_ready,
        output in_ready, out_valid, out_data, out_addr, out_last, row_idx, ovf, addr_err
    );
endinterface

// File: rtl/acc_bank.sv
// One-row register-file scratchpad: two accumulate ports plus a read port that clears on drain.
module acc_bank
    import sparse_pkg::*;
#(
    parameter int ROW_LEN = DEFAULT_ROW_LEN,
    parameter int ACC_W   = DEFAULT_ACC_W,
    parameter int IDX_W   = $clog2(ROW_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wr1En,
    input  logic [IDX_W-1:0]        i_wr1Addr,
    input  logic signed [ACC_W-1:0] i_wr1Data,
    output logic                    o_wr1Ovf,
    input  logic                    i_wr2En,
    input  logic [IDX_W-1:0]        i_wr2Addr,
    input  logic signed [ACC_W-1:0] i_wr2Data,
    output logic                    o_wr2Ovf,
    input  logic [IDX_W-1:0]        i_rdAddr,
    input  logic                    i_clrEn,
    output logic signed [ACC_W-1:0] o_rdData
);

    logic signed [ACC_W-1:0] r_acc [ROW_LEN];
    logic signed [ACC_W-1:0] w_old1, w_old2, w_sum1, w_sum2;

    assign w_old1   = r_acc[i_wr1Addr];
    assign w_old2   = r_acc[i_wr2Addr];
    assign w_sum1   = w_old1 + i_wr1Data;
    assign w_sum2   = w_old2 + i_wr2Data;
    assign o_wr1Ovf = i_wr1En && sign_ovf(w_old1[ACC_W-1], i_wr1Data[ACC_W-1], w_sum1[ACC_W-1]);
    assign o_wr2Ovf = i_wr2En && sign_ovf(w_old2[ACC_W-1], i_wr2Data[ACC_W-1], w_sum2[ACC_W-1]);
    assign o_rdData = r_acc[i_rdAddr];

    // The two lanes always target adjacent columns, so they never collide on one entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROW_LEN; i++) r_acc[i] <= '0;
        end else begin
            for (int i = 0; i < ROW_LEN; i++) begin
                if (i_clrEn && (i_rdAddr == IDX_W'(i))) begin
                    r_acc[i] <= '0;
                end else if (i_wr1En && (i_wr1Addr == IDX_W'(i))) begin
                    r_acc[i] <= w_sum1;
                end else if (i_wr2En && (i_wr2Addr == IDX_W'(i))) begin
                    r_acc[i] <= w_sum2;
                end
            end
        end
    end

endmodule

// File: rtl/row_accumulator.sv
// Accumulates two-lane product beats into a row scratchpad, then streams the row out and clears it.
module row_accumulator
    import sparse_pkg::*;
#(
    parameter int ROW_LEN = DEFAULT_ROW_LEN,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int ACC_W   = DEFAULT_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    row_accumulator_if.slave bus
);

    localparam int                IDX_W       = $clog2(ROW_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(ROW_LEN - 1);
    localparam logic [ADDR_W:0]   ROW_LEN_EXT = (ADDR_W + 1)'(ROW_LEN);

    racc_state_t             r_state;
    logic [IDX_W-1:0]        r_cnt;
    logic                    r_inReady;
    logic                    r_outValid;
    logic [15:0]             r_rowIdx;
    logic                    r_ovf;
    logic                    r_addrErr;

    logic [ADDR_W:0]         w_addr1Ext, w_addr2Ext;
    logic                    w_lane1Ok, w_lane2Ok;
    logic                    w_beat, w_accum, w_drainHs;
    logic                    w_ovf1, w_ovf2;
    logic signed [ACC_W-1:0] w_rdData;

    // Extra address bit keeps in_addr+1 from wrapping back into range.
    assign w_addr1Ext = {1'b0, bus.in_addr};
    assign w_addr2Ext = w_addr1Ext + (ADDR_W + 1)'(1);
    assign w_lane1Ok  = w_addr1Ext < ROW_LEN_EXT;
    assign w_lane2Ok  = w_addr2Ext < ROW_LEN_EXT;
    assign w_beat     = bus.in_valid && r_inReady;
    assign w_accum    = w_beat && !bus.in_zeros;
    assign w_drainHs  = r_outValid && bus.out_ready;

    acc_bank #(
        .ROW_LEN (ROW_LEN),
        .ACC_W   (ACC_W),
        .IDX_W   (IDX_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .i_wr1En   (w_accum && w_lane1Ok),
        .i_wr1Addr (w_addr1Ext[IDX_W-1:0]),
        .i_wr1Data (bus.in_data1),
        .o_wr1Ovf  (w_ovf1),
        .i_wr2En   (w_accum && w_lane2Ok),
        .i_wr2Addr (w_addr2Ext[IDX_W-1:0]),
        .i_wr2Data (bus.in_data2),
        .o_wr2Ovf  (w_ovf2),
        .i_rdAddr  (r_cnt),
        .i_clrEn   (w_drainHs),
        .o_rdData  (w_rdData)
    );

    assign bus.in_ready  = r_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.out_data  = r_outValid ? w_rdData : '0;
    assign bus.out_addr  = ADDR_W'(r_cnt);
    assign bus.out_last  = r_outValid && (r_cnt == LAST_IDX);
    assign bus.row_idx   = r_rowIdx;
    assign bus.ovf       = r_ovf;
    assign bus.addr_err  = r_addrErr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ACCUM;
            r_cnt      <= '0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_rowIdx   <= '0;
            r_ovf      <= 1'b0;
            r_addrErr  <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accum) begin
                        r_ovf     <= r_ovf | w_ovf1 | w_ovf2;
                        r_addrErr <= r_addrErr | !w_lane2Ok;
                    end
                    if (w_beat && bus.in_last) begin
                        r_state    <= DRAIN;
                        r_cnt      <= '0;
                        r_inReady  <= 1'b0;
                        r_outValid <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_drainHs) begin
                        if (r_cnt == LAST_IDX) begin
                            r_state    <= ACCUM;
                            r_cnt      <= '0;
                            r_inReady  <= 1'b1;
                            r_outValid <= 1'b0;
                            r_rowIdx   <= r_rowIdx + 16'd1;
                        end else begin
                            r_cnt <= r_cnt + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_row_accumulator.sv
// Self-checking bench for row_accumulator (ROW_LEN=8): beat table, reference row model, drain scoreboard.
module tb_row_accumulator;
    import sparse_pkg::*;

    localparam int RL = 8;
    localparam int AW = 10;
    localparam int DW = 64;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        logic    zeros;
        logic    last;
        int      addr;
        longint  d1;
        longint  d2;
        logic [3:0] pat;
        int      npat;
        logic    expOvf;
        logic    expErr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   expRow = 0;
    longint model [RL];
    exp_t   sbq [$];
    vec_t   vecs [10];

    always #5 clk = ~clk;

    row_accumulator_if #(.ADDR_W(AW), .ACC_W(DW)) bus ();

    row_accumulator #(.ROW_LEN(RL), .ADDR_W(AW), .ACC_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(logic z, logic l, int a, longint d1, longint d2,
                                   logic [3:0] p, int n, logic eo, logic ee);
        vec_t v;
        v.zeros = z; v.last = l; v.addr = a; v.d1 = d1; v.d2 = d2;
        v.pat = p; v.npat = n; v.expOvf = eo; v.expErr = ee;
        return v;
    endfunction

    // Drives one beat, waits (bounded) for acceptance, and updates the reference row.
    task automatic applyStimulus(input vec_t v);
        int w = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_zeros = v.zeros;
        bus.in_last  = v.last;
        bus.in_addr  = AW'(v.addr);
        bus.in_data1 = v.d1;
        bus.in_data2 = v.d2;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput("in_ready for beat", bus.in_ready, 1);
        if (!v.zeros) begin
            if (v.addr < RL)     model[v.addr]     = model[v.addr] + v.d1;
            if (v.addr + 1 < RL) model[v.addr + 1] = model[v.addr + 1] + v.d2;
        end
        if (v.last) begin
            for (int i = 0; i < RL; i++) begin
                exp_t e;
                e.addr = AW'(i);
                e.data = model[i];
                e.last = (i == RL - 1);
                sbq.push_back(e);
                model[i] = 0;
            end
        end
    endtask

    // Drains one row under a repeating out_ready pattern; abortAt>=0 asserts rst at that element.
    task automatic drainRow(input logic [3:0] pat, input int npat, input int abortAt);
        int hs = 0;
        int cyc = 0;
        int k = 0;
        logic stalled = 1'b0;
        logic [DW-1:0] pData = '0;
        logic [AW-1:0] pAddr = '0;
        logic pLast = 1'b0;
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        checkOutput("out_valid one cycle after last", bus.out_valid, 1);
        while (hs < RL && cyc < 100) begin
            if (hs == abortAt) begin
                rst = 1'b1;
                #1;
                checkOutput("rst out_valid", bus.out_valid, 0);
                checkOutput("rst in_ready", bus.in_ready, 1);
                checkOutput("rst out_data", bus.out_data, 0);
                checkOutput("rst out_addr", bus.out_addr, 0);
                checkOutput("rst row_idx", bus.row_idx, 0);
                checkOutput("rst ovf", bus.ovf, 0);
                checkOutput("rst addr_err", bus.addr_err, 0);
                sbq.delete();
                expRow = 0;
                bus.out_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            bus.out_ready = pat[k % npat];
            k++;
            if (bus.out_valid) begin
                checkOutput("in_ready low in drain", bus.in_ready, 0);
                if (stalled) begin
                    checkOutput("stall out_data", bus.out_data, pData);
                    checkOutput("stall out_addr", bus.out_addr, pAddr);
                    checkOutput("stall out_last", bus.out_last, pLast);
                end
                if (bus.out_ready) begin
                    if (sbq.size() == 0) begin
                        checkOutput("unexpected element", bus.out_valid, 0);
                    end else begin
                        e = sbq.pop_front();
                        checkOutput("out_addr", bus.out_addr, e.addr);
                        checkOutput("out_data", bus.out_data, e.data);
                        checkOutput("out_last", bus.out_last, e.last);
                    end
                    hs++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pData = bus.out_data;
                    pAddr = bus.out_addr;
                    pLast = bus.out_last;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b0;
        checkOutput("drain handshakes", hs, RL);
        checkOutput("out_valid after drain", bus.out_valid, 0);
        checkOutput("in_ready after drain", bus.in_ready, 1);
        expRow++;
        checkOutput("row_idx", bus.row_idx, expRow);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < RL; i++) model[i] = 0;
        bus.in_valid = 1'b0; bus.in_zeros = 1'b0; bus.in_last = 1'b0;
        bus.in_addr = '0; bus.in_data1 = '0; bus.in_data2 = '0; bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", bus.in_ready, 1);
        checkOutput("reset out_valid", bus.out_valid, 0);
        checkOutput("reset out_data", bus.out_data, 0);
        checkOutput("reset out_addr", bus.out_addr, 0);
        checkOutput("reset out_last", bus.out_last, 0);
        checkOutput("reset row_idx", bus.row_idx, 0);
        checkOutput("reset ovf", bus.ovf, 0);
        checkOutput("reset addr_err", bus.addr_err, 0);
        rst = 1'b0;

        vecs[0] = mkVec(0, 1, 2, 5, 7, 4'b1111, 1, 0, 0);
        vecs[1] = mkVec(0, 0, 3, 10, 0, 4'b1111, 1, 0, 0);
        vecs[2] = mkVec(0, 0, 2, 0, -4, 4'b1111, 1, 0, 0);
        vecs[3] = mkVec(1, 1, 0, 77, 88, 4'b1111, 1, 0, 0);
        vecs[4] = mkVec(1, 1, 5, 99, 99, 4'b1001, 4, 0, 0);
        vecs[5] = mkVec(0, 0, 0, 64'sh7FFF_FFFF_FFFF_FFFF, 0, 4'b1111, 1, 0, 0);
        vecs[6] = mkVec(0, 0, 0, 1, 0, 4'b1111, 1, 0, 0);
        vecs[7] = mkVec(0, 0, 7, 3, 9, 4'b1111, 1, 0, 0);
        vecs[8] = mkVec(0, 0, 9, 100, 100, 4'b1111, 1, 0, 0);
        vecs[9] = mkVec(1, 1, 0, 0, 0, 4'b1111, 1, 1, 1);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            if (vecs[i].last) begin
                drainRow(vecs[i].pat, vecs[i].npat, -1);
                checkOutput("ovf sticky", bus.ovf, vecs[i].expOvf);
                checkOutput("addr_err sticky", bus.addr_err, vecs[i].expErr);
            end
        end

        applyStimulus(mkVec(0, 1, 4, 11, 12, 4'b1111, 1, 0, 0));
        drainRow(4'b1111, 1, 4);
        applyStimulus(mkVec(1, 1, 0, 55, 66, 4'b1111, 1, 0, 0));
        drainRow(4'b1111, 1, -1);
        checkOutput("ovf after reset", bus.ovf, 0);
        checkOutput("addr_err after reset", bus.addr_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
